bram_arbiter: RTL

Two-requester arbiter and sequencer for the single-port `BRAM` block (32-bit × 512 default). It shares the one BRAM port between requester A (instruction fetch) and requester B (load/store), using valid/ready requests and round-robin arbitration. It registers the BRAM control inputs and routes the synchronous read data back to the requester that issued the read. It sits directly between the core's memory ports and the `BRAM` instance.

---
 rtl/bram_arb_pkg.sv | 25 ++
 rtl/bram_rr_pick.sv | 25 ++
 rtl/bram_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared types and constants for the BRAM arbiter slice.
//   arb_state_t : arbiter operating state (ST_CLEAR sweep, ST_IDLE running)
//   req_id_t    : requester identity (REQ_A = instruction fetch, REQ_B = load/store)
//   tag_t       : response tag carried alongside each BRAM access
package bram_arb_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } arb_state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    typedef struct packed {
        logic    valid;   // access was a read and expects a response
        req_id_t id;      // requester that issued the read
    } tag_t;

    localparam int unsigned TAG_W      = $bits(tag_t);
    localparam int unsigned TAG_STAGES = 2;

endpackage

// File: rtl/bram_rr_pick.sv
// bram_rr_pick: combinational two-way round-robin picker.
// Ports:
//   a_valid, b_valid : request present from requester A / B
//   last_grant       : requester granted on the most recent accepted transfer
//   grant[1:0]       : one-hot grant, bit 0 = A, bit 1 = B (all-zero if no request)
module bram_rr_pick
    import bram_arb_pkg::*;
(
    input  logic       a_valid,
    input  logic       b_valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        // On contention the requester that did not win last time goes first.
        if (a_valid && (!b_valid || (last_grant == REQ_B))) begin
            grant[0] = 1'b1;
        end else if (b_valid) begin
            grant[1] = 1'b1;
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one single-port BRAM between requester A (fetch) and
// requester B (load/store) with round-robin arbitration, registered BRAM
// controls and a two-stage response tag that routes read data back.
// Read latency is two clock edges from acceptance to the rvalid sample.
// Ports:
//   clock, reset_n             : clock, asynchronous active-low reset
//   a_/b_valid, _write,
//   _address, _wdata           : requests (valid/ready handshake)
//   a_/b_ready                 : request accepted this cycle (combinational)
//   a_/b_rvalid, rdata         : read response pulse, shared read data
//   busy                       : clear sweep in progress
//   ram_enable, write_enable,
//   address, input_data        : registered BRAM controls
//   output_data                : BRAM synchronous read data
// Optional feature: define BRAM_ARB_CLEAR_EN to zero the whole BRAM after
// every reset release before any request is accepted.
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int RAM_WIDTH     = 32,
    parameter int RAM_ADDR_BITS = 9
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     a_valid,
    input  logic                     a_write,
    input  logic [RAM_ADDR_BITS-1:0] a_address,
    input  logic [RAM_WIDTH-1:0]     a_wdata,
    output logic                     a_ready,
    output logic                     a_rvalid,
    input  logic                     b_valid,
    input  logic                     b_write,
    input  logic [RAM_ADDR_BITS-1:0] b_address,
    input  logic [RAM_WIDTH-1:0]     b_wdata,
    output logic                     b_ready,
    output logic                     b_rvalid,
    output logic [RAM_WIDTH-1:0]     rdata,
    output logic                     busy,
    output logic                     ram_enable,
    output logic                     write_enable,
    output logic [RAM_ADDR_BITS-1:0] address,
    output logic [RAM_WIDTH-1:0]     input_data,
    input  logic [RAM_WIDTH-1:0]     output_data
);

    arb_state_t                 state_q, state_d;
    req_id_t                    last_grant_q;
    tag_t                       tag_s1_q, tag_s2_q;
    logic [1:0]                 grant;
    logic                       running;
    logic                       accept;
    logic                       sel_b;
    logic                       clearing;
    logic [RAM_ADDR_BITS-1:0]   clr_addr;
    logic                       req_write;
    logic [RAM_ADDR_BITS-1:0]   req_address;
    logic [RAM_WIDTH-1:0]       req_wdata;

    bram_rr_pick u_pick (
        .a_valid    (a_valid),
        .b_valid    (b_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // Readies are also masked by reset_n so nothing looks accepted while the
    // block is held in reset.
    assign running = (state_q == ST_IDLE) && reset_n;
    assign a_ready = running && grant[0];
    assign b_ready = running && grant[1];
    assign accept  = a_ready || b_ready;
    assign sel_b   = b_ready;

    assign req_write   = sel_b ? b_write   : a_write;
    assign req_address = sel_b ? b_address : a_address;
    assign req_wdata   = sel_b ? b_wdata   : a_wdata;

`ifdef BRAM_ARB_CLEAR_EN
    logic [RAM_ADDR_BITS-1:0] clr_cnt_q;

    assign clearing = (state_q == ST_CLEAR);
    assign clr_addr = clr_cnt_q;
    assign busy     = clearing;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clr_cnt_q <= '0;
        end else if (clearing) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clearing && (clr_cnt_q == '1)) begin
            state_d = ST_IDLE;
        end
    end
`else
    assign clearing = 1'b0;
    assign clr_addr = '0;
    assign busy     = 1'b0;

    always_comb begin
        state_d = state_q;
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
`ifdef BRAM_ARB_CLEAR_EN
            state_q      <= ST_CLEAR;
`else
            state_q      <= ST_IDLE;
`endif
            last_grant_q <= REQ_B;
            tag_s1_q     <= '0;
            tag_s2_q     <= '0;
            ram_enable   <= 1'b0;
            write_enable <= 1'b0;
            address      <= '0;
            input_data   <= '0;
        end else begin
            state_q <= state_d;

            // Stage 1 lines up with the BRAM sampling edge, stage 2 with the
            // cycle its read data is on output_data.
            tag_s1_q.valid <= accept && !req_write;
            tag_s1_q.id    <= sel_b ? REQ_B : REQ_A;
            tag_s2_q       <= tag_s1_q;

            if (clearing) begin
                ram_enable   <= 1'b1;
                write_enable <= 1'b1;
                address      <= clr_addr;
                input_data   <= '0;
            end else if (accept) begin
                ram_enable   <= 1'b1;
                write_enable <= req_write;
                address      <= req_address;
                input_data   <= req_wdata;
                last_grant_q <= sel_b ? REQ_B : REQ_A;
            end else begin
                ram_enable   <= 1'b0;
                write_enable <= 1'b0;
            end
        end
    end

    assign a_rvalid = tag_s2_q.valid && (tag_s2_q.id == REQ_A);
    assign b_rvalid = tag_s2_q.valid && (tag_s2_q.id == REQ_B);
    assign rdata    = output_data;

endmodule
